serial_adder_pipe: RTL and testbench

- Parametrised bit-serial adder/subtractor; next generation of the team's NAND-built half-adder cell.
- Adds or subtracts two WIDTH-bit operands one bit per clock, LSB first, using a single registered carry.
- Valid/ready handshake on input and output; intended as the low-area arithmetic unit feeding the datapath.

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/full_adder_nand_cell.sv | 24 ++
 rtl/serial_adder_pipe.sv | 149 ++++++++++++++
 tb/tb_serial_adder_pipe.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder/subtractor.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int unsigned WIDTH_MIN = 2;
   localparam int unsigned WIDTH_MAX = 64;

endpackage

// File: rtl/full_adder_nand_cell.sv
// Combinational full adder: two NAND-built half-adder stages plus a carry OR.
module full_adder_nand_cell (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic sum_c,
   output logic cout_c
);

   logic n1, x1, c1;
   logic n2, c2;

   // first half adder: a + b
   assign n1 = ~(a_i & b_i);
   assign x1 = ~(~(a_i & n1) & ~(b_i & n1));
   assign c1 = ~n1;

   // second half adder: partial sum + carry in
   assign n2     = ~(x1 & cin_i);
   assign sum_c  = ~(~(x1 & n2) & ~(cin_i & n2));
   assign c2     = ~n2;
   assign cout_c = c1 | c2;

endmodule

// File: rtl/serial_adder_pipe.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock with valid/ready handshakes.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_pipe
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int unsigned      CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("serial_adder_pipe: WIDTH out of range");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic fa_sum_c;
   logic fa_cout_c;

   full_adder_nand_cell u_fa (
      .a_i    (a_sh_q[0]),
      .b_i    (b_sh_q[0]),
      .cin_i  (carry_q),
      .sum_c  (fa_sum_c),
      .cout_c (fa_cout_c)
   );

   // next-state and datapath update
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d    = ovf_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = sub ? ~b : b;
               carry_d = sub;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            sum_sh_d = {fa_sum_c, sum_sh_q[WIDTH-1:1]};
            carry_d  = fa_cout_c;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
               sum_d   = sum_sh_d;
               cout_d  = fa_cout_c;
`ifdef SERIAL_ADDER_OVF_EN
               // carry into the MSB is the carry held while the MSB is processed
               ovf_d   = carry_q ^ fa_cout_c;
`endif
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         sum_sh_q    <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         sum_sh_q    <= sum_sh_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_pipe.sv
// Directed bench for serial_adder_pipe (WIDTH=8); checks ovf when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_pipe;

   localparam int unsigned W = 8;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
      logic         exp_ovf;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int total = 0;
   int bad   = 0;

   serial_adder_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
`ifdef SERIAL_ADDER_OVF_EN
      .ovf       (ovf),
`endif
      .cout      (cout)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one full transaction; in_valid stays high with junk operands during RUN
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                         input logic [W-1:0] es, input logic ec, input logic eo, input string nm);
      int cyc;
      int rdy_hi;
      check({nm, " ready_before"}, 64'(in_ready), 64'd1);
      a = av; b = bv; sub = sv; in_valid = 1'b1;
      tick();
      a = ~av; b = av ^ 8'h5A; sub = ~sv;
      cyc = 0;
      rdy_hi = 0;
      while (!out_valid && cyc < 20) begin
         if (in_ready) rdy_hi++;
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      check({nm, " latency"}, 64'(cyc), 64'(W));
      check({nm, " ready_low_run"}, 64'(rdy_hi), 64'd0);
      check({nm, " ready_low_done"}, 64'(in_ready), 64'd0);
      check({nm, " sum"}, 64'(sum), 64'(es));
      check({nm, " cout"}, 64'(cout), 64'(ec));
`ifdef SERIAL_ADDER_OVF_EN
      check({nm, " ovf"}, 64'(ovf), 64'(eo));
`else
      if (eo === 1'bx) $display("note: %s has unknown ovf expectation", nm);
`endif
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({nm, " idle_ready"}, 64'(in_ready), 64'd1);
      check({nm, " idle_valid"}, 64'(out_valid), 64'd0);
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0};
      vecs[3] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0};
      vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[5] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
      vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};
      vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[8] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[9] = '{8'h3C, 8'hC4, 1'b0, 8'h00, 1'b1, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; sub = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset in_ready", 64'(in_ready), 64'd1);
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset sum", 64'(sum), 64'd0);
      check("reset cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check("reset ovf", 64'(ovf), 64'd0);
`endif

      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp_sum,
                vecs[i].exp_cout, vecs[i].exp_ovf, $sformatf("vec%0d", i));
      end

      // backpressure: result held while out_ready is low, in_valid pulses ignored
      begin
         int cyc;
         a = 8'h12; b = 8'h34; sub = 1'b0; in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         cyc = 0;
         while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
         end
         check("bp latency", 64'(cyc), 64'(W));
         for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            a = 8'hF0 + 8'(k); b = 8'h0F; sub = k[1];
            tick();
            check($sformatf("bp%0d valid", k), 64'(out_valid), 64'd1);
            check($sformatf("bp%0d ready", k), 64'(in_ready), 64'd0);
            check($sformatf("bp%0d sum", k), 64'(sum), 64'h46);
            check($sformatf("bp%0d cout", k), 64'(cout), 64'd0);
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         check("bp idle ready", 64'(in_ready), 64'd1);
         check("bp idle valid", 64'(out_valid), 64'd0);
         for (int k = 0; k < 10; k++) tick();
         check("bp no stray op", 64'(out_valid), 64'd0);
         check("bp still idle", 64'(in_ready), 64'd1);
      end

      // reset in the middle of RUN discards the operation
      a = 8'h55; b = 8'h22; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      check("midrun busy", 64'(in_ready), 64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrun rst valid", 64'(out_valid), 64'd0);
      check("midrun rst ready", 64'(in_ready), 64'd1);
      check("midrun rst sum", 64'(sum), 64'd0);
      check("midrun rst cout", 64'(cout), 64'd0);
      for (int k = 0; k < 12; k++) tick();
      check("midrun no result", 64'(out_valid), 64'd0);
      run_op(8'h64, 8'h32, 1'b1, 8'h32, 1'b1, 1'b0, "post_rst");

      // reset while DONE also discards the held result
      a = 8'h0A; b = 8'h0B; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < W; k++) tick();
      check("done reached", 64'(out_valid), 64'd1);
      check("done sum", 64'(sum), 64'h15);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("done rst valid", 64'(out_valid), 64'd0);
      check("done rst sum", 64'(sum), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
